// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter with a runtime clock-per-bit divisor.
// Each accepted word goes out as a start bit, DATA_WIDTH data bits (LSB first),
// an optional parity bit and STOP_BITS stop bits. Bit timing comes from a
// clock-enable timer in the clk domain.
//
// Ports:
//   clk      system clock
//   i_reset  synchronous, active-high reset
//   i_div    clk cycles per bit, latched at accept (values below 2 act as 2)
//   i_data   word to send, latched at accept
//   i_valid  source has a word
//   o_ready  word accepted this cycle when i_valid is also high
//   o_tx     registered serial line, idle high
//   o_busy   frame in progress
//   o_done   single-cycle pulse on the final cycle of the last stop bit
module uart_tx_cfg #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic [DIV_WIDTH-1:0]  i_div,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]     BIT_LAST  = CNT_W'(DATA_WIDTH - 1);
    localparam logic                 STOP_LAST = (STOP_BITS == 2);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_MIN   = DIV_WIDTH'(2);

    logic [2:0]            state;
    logic [DIV_WIDTH-1:0]  timer;
    logic [DIV_WIDTH-1:0]  div_l;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  stop_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_bit;
    logic                  tx_q;

    logic                  bit_wrap;
    logic                  frame_end;
    logic                  accept;
    logic [DIV_WIDTH-1:0]  div_eff;
    logic                  par_new;

    always_comb begin
        bit_wrap  = (timer == (div_l - DIV_ONE));
        frame_end = (state == S_STOP) && (stop_cnt == STOP_LAST) && bit_wrap;
        o_ready   = (state == S_IDLE) || frame_end;
        o_done    = frame_end;
        o_busy    = (state != S_IDLE);
        o_tx      = tx_q;
        accept    = i_valid && o_ready;
        div_eff   = (i_div < DIV_MIN) ? DIV_MIN : i_div;
        par_new   = (PARITY == 2) ? ~(^i_data) : (^i_data);
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state    <= S_IDLE;
            timer    <= '0;
            div_l    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            tx_q     <= 1'b1;
        end else if (accept) begin
            // Accept can happen in IDLE or on the final stop cycle; both start a frame.
            state    <= S_START;
            tx_q     <= 1'b0;
            timer    <= '0;
            div_l    <= div_eff;
            shreg    <= i_data;
            par_bit  <= par_new;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
        end else if (state != S_IDLE) begin
            if (!bit_wrap) begin
                timer <= timer + DIV_ONE;
            end else begin
                timer <= '0;
                case (state)
                    S_START: begin
                        state   <= S_DATA;
                        tx_q    <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= '0;
                    end
                    S_DATA: begin
                        if (bit_cnt == BIT_LAST) begin
                            if (PARITY != 0) begin
                                state <= S_PARITY;
                                tx_q  <= par_bit;
                            end else begin
                                state    <= S_STOP;
                                tx_q     <= 1'b1;
                                stop_cnt <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx_q    <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                    S_PARITY: begin
                        state    <= S_STOP;
                        tx_q     <= 1'b1;
                        stop_cnt <= 1'b0;
                    end
                    S_STOP: begin
                        if (stop_cnt == STOP_LAST) begin
                            state <= S_IDLE;
                            tx_q  <= 1'b1;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        tx_q  <= 1'b1;
                    end
                endcase
            end
        end else begin
            tx_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: five transmitter configurations run side by side; each is
// compared cycle by cycle against a frame model that expands every accepted
// word into its bit list and indexes it by elapsed time / divisor.
module tb_uart_tx_cfg;

    localparam int NL   = 5;
    localparam int NCYC = 9000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] div  [NL];
    logic [8:0]  data [NL];
    logic [NL-1:0] vld;
    logic [NL-1:0] tx, busy, done, rdy;

    uart_tx_cfg #(.DATA_WIDTH(8), .DIV_WIDTH(16), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .i_reset(rst), .i_div(div[0]), .i_data(data[0][7:0]), .i_valid(vld[0]),
        .o_ready(rdy[0]), .o_tx(tx[0]), .o_busy(busy[0]), .o_done(done[0]));
    uart_tx_cfg #(.DATA_WIDTH(8), .DIV_WIDTH(16), .PARITY(0), .STOP_BITS(2)) u1 (
        .clk(clk), .i_reset(rst), .i_div(div[1]), .i_data(data[1][7:0]), .i_valid(vld[1]),
        .o_ready(rdy[1]), .o_tx(tx[1]), .o_busy(busy[1]), .o_done(done[1]));
    uart_tx_cfg #(.DATA_WIDTH(8), .DIV_WIDTH(16), .PARITY(1), .STOP_BITS(1)) u2 (
        .clk(clk), .i_reset(rst), .i_div(div[2]), .i_data(data[2][7:0]), .i_valid(vld[2]),
        .o_ready(rdy[2]), .o_tx(tx[2]), .o_busy(busy[2]), .o_done(done[2]));
    uart_tx_cfg #(.DATA_WIDTH(8), .DIV_WIDTH(16), .PARITY(2), .STOP_BITS(1)) u3 (
        .clk(clk), .i_reset(rst), .i_div(div[3]), .i_data(data[3][7:0]), .i_valid(vld[3]),
        .o_ready(rdy[3]), .o_tx(tx[3]), .o_busy(busy[3]), .o_done(done[3]));
    uart_tx_cfg #(.DATA_WIDTH(5), .DIV_WIDTH(16), .PARITY(1), .STOP_BITS(2)) u4 (
        .clk(clk), .i_reset(rst), .i_div(div[4]), .i_data(data[4][4:0]), .i_valid(vld[4]),
        .o_ready(rdy[4]), .o_tx(tx[4]), .o_busy(busy[4]), .o_done(done[4]));

    function automatic int cfg_dw(input int l);
        return (l == 4) ? 5 : 8;
    endfunction
    function automatic int cfg_par(input int l);
        case (l)
            2: return 1;
            3: return 2;
            4: return 1;
            default: return 0;
        endcase
    endfunction
    function automatic int cfg_stop(input int l);
        return (l == 1 || l == 4) ? 2 : 1;
    endfunction

    typedef struct {
        bit          active;
        int          t;
        int          dv;
        logic [15:0] bits;
        int          nbits;
    } lane_t;

    lane_t m [NL];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic m_tx(input int l);
        if (!m[l].active) return 1'b1;
        return m[l].bits[m[l].t / m[l].dv];
    endfunction
    function automatic logic m_done(input int l);
        return m[l].active && (m[l].t == m[l].nbits * m[l].dv - 1);
    endfunction
    function automatic logic m_ready(input int l);
        return !m[l].active || m_done(l);
    endfunction

    task automatic start_frame(input int l, input logic [8:0] d, input logic [15:0] dv);
        logic [15:0] b;
        logic        p;
        int          k;
        b = '1;
        p = 1'b0;
        b[0] = 1'b0;
        for (int i = 0; i < cfg_dw(l); i++) begin
            b[1 + i] = d[i];
            p = p ^ d[i];
        end
        k = 1 + cfg_dw(l);
        if (cfg_par(l) != 0) begin
            b[k] = (cfg_par(l) == 2) ? ~p : p;
            k++;
        end
        m[l].bits   = b;
        m[l].nbits  = k + cfg_stop(l);
        m[l].dv     = (dv < 16'd2) ? 2 : int'(dv);
        m[l].t      = 0;
        m[l].active = 1'b1;
    endtask

    function automatic logic [8:0] dir_word(input int l, input int n);
        case (l)
            0: return (n == 0) ? 9'h055 : 9'h033;
            1: return (n == 0) ? 9'h0A5 : 9'h03C;
            2: return (n == 0) ? 9'h007 : 9'h1E0;
            3: return (n == 0) ? 9'h007 : 9'h000;
            default: return (n == 0) ? 9'h1FF : 9'h00A;
        endcase
    endfunction

    int  nsent     [NL];
    int  first_acc [NL];
    int  first_dn  [NL];
    bit  taken     [NL];

    initial begin
        rst = 1'b1;
        for (int l = 0; l < NL; l++) begin
            vld[l]       = 1'b0;
            data[l]      = '0;
            div[l]       = 16'd4;
            m[l].active  = 1'b0;
            m[l].t       = 0;
            m[l].dv      = 2;
            m[l].bits    = '1;
            m[l].nbits   = 1;
            nsent[l]     = 0;
            first_acc[l] = -1;
            first_dn[l]  = -1;
            taken[l]     = 1'b0;
        end
        @(negedge clk);

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            for (int l = 0; l < NL; l++) begin
                check($sformatf("l%0d_tx@%0d", l, cyc),    32'(tx[l]),   32'(m_tx(l)));
                check($sformatf("l%0d_busy@%0d", l, cyc),  32'(busy[l]), 32'(m[l].active));
                check($sformatf("l%0d_done@%0d", l, cyc),  32'(done[l]), 32'(m_done(l)));
                check($sformatf("l%0d_ready@%0d", l, cyc), 32'(rdy[l]),  32'(m_ready(l)));
                if (done[l] === 1'b1 && first_dn[l] < 0) first_dn[l] = cyc;
            end

            rst = 1'b0;
            for (int l = 0; l < NL; l++) if (taken[l]) vld[l] = 1'b0;

            if (cyc < 200) begin
                for (int l = 0; l < NL; l++) begin
                    if (!vld[l] && nsent[l] < 2) begin
                        vld[l]  = 1'b1;
                        data[l] = dir_word(l, nsent[l]);
                        nsent[l]++;
                    end
                end
                div[0] = (cyc < 20) ? 16'd4 : 16'd10;
                div[1] = 16'd4;
                div[2] = 16'd3;
                div[3] = 16'd3;
                div[4] = (cyc < 40) ? 16'd0 : 16'd1;
            end else if (cyc < 300) begin
                div[0] = 16'd4;
                if (cyc == 200) begin
                    vld[0]  = 1'b1;
                    data[0] = 9'h05A;
                end
                if (cyc == 218) rst = 1'b1;
                if (cyc == 220) begin
                    vld[0]  = 1'b1;
                    data[0] = 9'h081;
                end
            end else begin
                for (int l = 0; l < NL; l++) begin
                    if (!vld[l] && $urandom_range(0, 2) == 0) begin
                        vld[l]  = 1'b1;
                        data[l] = 9'($urandom_range(0, 511));
                    end
                    if ($urandom_range(0, 3) == 0) div[l] = 16'($urandom_range(0, 6));
                end
                rst = ($urandom_range(0, 1499) == 0);
            end

            for (int l = 0; l < NL; l++) begin
                bit acc;
                acc = vld[l] && m_ready(l) && !rst;
                if (rst) begin
                    m[l].active = 1'b0;
                end else if (m[l].active) begin
                    m[l].t++;
                    if (m[l].t == m[l].nbits * m[l].dv) m[l].active = 1'b0;
                end
                if (acc) begin
                    start_frame(l, data[l], div[l]);
                    if (first_acc[l] < 0) first_acc[l] = cyc;
                end
                taken[l] = acc;
            end

            @(negedge clk);
        end

        check("l0_8n1_div4_len",   32'(first_dn[0] - first_acc[0]), 32'd40);
        check("l1_8n2_div4_len",   32'(first_dn[1] - first_acc[1]), 32'd44);
        check("l2_8e1_div3_len",   32'(first_dn[2] - first_acc[2]), 32'd33);
        check("l3_8o1_div3_len",   32'(first_dn[3] - first_acc[3]), 32'd33);
        check("l4_5e2_div0_len",   32'(first_dn[4] - first_acc[4]), 32'd18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
